mario_anim_ctrl: RTL

Animation sequencer and fetch scheduler for the big-Mario sprite ROM set (still, three walk frames, jump; each a 21×41 palette-indexed ROM with a combinational 10-bit read port and 12-bit colour out). Once per video frame it picks the sprite frame and facing direction from player-motion inputs. Every pixel clock it turns the VGA draw position into a ROM select and read address, mirroring for left-facing. It then returns a registered, transparency-filtered colour to the frame compositor.

---
 rtl/mario_anim_ctrl.sv | 111 +++++++++++
 1 files changed

// File: rtl/mario_anim_ctrl.sv
// Big-Mario animation sequencer and sprite-ROM fetch scheduler.
// Picks the sprite frame and facing once per video frame, then streams ROM reads per pixel.
module mario_anim_ctrl #(
    parameter int unsigned SPR_W    = 21,
    parameter int unsigned SPR_H    = 41,
    parameter int unsigned WALK_DIV = 6,
    parameter logic [11:0] TRANSP   = 12'h808
) (
    input  logic        Clk,
    input  logic        reset_n,
    input  logic        frame_tick,
    input  logic        walk_req,
    input  logic        face_left_req,
    input  logic        airborne,
    input  logic [9:0]  mario_x,
    input  logic [9:0]  mario_y,
    input  logic [9:0]  draw_x,
    input  logic [9:0]  draw_y,
    output logic [2:0]  rom_sel,
    output logic [9:0]  rom_addr,
    input  logic [11:0] rom_color,
    output logic        pix_valid,
    output logic [11:0] pix_color,
    output logic [2:0]  anim_state
);

    typedef enum logic [2:0] {
        StStill = 3'd0,
        StWalk1 = 3'd1,
        StWalk2 = 3'd2,
        StWalk3 = 3'd3,
        StJump  = 3'd4
    } anim_state_e;

    localparam int unsigned CntW = (WALK_DIV > 1) ? $clog2(WALK_DIV) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WALK_DIV - 1);

    anim_state_e         state_q, state_d;
    logic                face_q, face_d;
    logic [CntW-1:0]     cnt_q, cnt_d;

    logic                in_box;
    logic [9:0]          dx, dy, col, addr_full;
    logic                in_box_d1_q;

    // Per-frame animation update; nothing changes between frame_tick pulses.
    always_comb begin
        state_d = state_q;
        face_d  = face_q;
        cnt_d   = cnt_q;
        if (frame_tick) begin
            face_d = face_left_req;
            cnt_d  = '0;
            if (airborne) begin
                state_d = StJump;
            end else if (!walk_req) begin
                state_d = StStill;
            end else begin
                unique case (state_q)
                    StWalk1: if (cnt_q == CntLast) state_d = StWalk2; else cnt_d = cnt_q + 1'b1;
                    StWalk2: if (cnt_q == CntLast) state_d = StWalk3; else cnt_d = cnt_q + 1'b1;
                    StWalk3: if (cnt_q == CntLast) state_d = StWalk1; else cnt_d = cnt_q + 1'b1;
                    default: state_d = StWalk1;
                endcase
            end
        end
    end

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StStill;
            face_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            face_q  <= face_d;
            cnt_q   <= cnt_d;
        end
    end

    // Box test widened to 11 bits so a sprite near x=1023 cannot wrap onto column 0.
    always_comb begin
        in_box = ({1'b0, draw_x} >= {1'b0, mario_x}) &&
                 ({1'b0, draw_x} <  {1'b0, mario_x} + 11'(SPR_W)) &&
                 ({1'b0, draw_y} >= {1'b0, mario_y}) &&
                 ({1'b0, draw_y} <  {1'b0, mario_y} + 11'(SPR_H));
        dx        = draw_x - mario_x;
        dy        = draw_y - mario_y;
        col       = face_q ? (10'(SPR_W - 1) - dx) : dx;
        addr_full = dy * 10'(SPR_W) + col;
    end

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            rom_addr    <= '0;
            rom_sel     <= 3'd0;
            in_box_d1_q <= 1'b0;
            pix_valid   <= 1'b0;
            pix_color   <= 12'h000;
        end else begin
            rom_addr    <= in_box ? addr_full : 10'd0;
            rom_sel     <= state_q;
            in_box_d1_q <= in_box;
            pix_valid   <= in_box_d1_q && (rom_color != TRANSP);
            pix_color   <= in_box_d1_q ? rom_color : 12'h000;
        end
    end

    assign anim_state = state_q;

endmodule
